// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C engine: runs one START/STOP/WRITE/READ bit as four timer-paced
// phases, drives open-drain SCL/SDA enables, handles clock stretching and arbitration.
module i2c_bit_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    output logic       Timer_start,
    output logic       Timer_stop,
    input  logic [1:0] Cmd,
    input  logic       Cmd_valid,
    input  logic       Din,
    output logic       Cmd_ack,
    output logic       Dout,
    output logic       Busy,
    output logic       Al,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Scl_oen,
    output logic       Sda_oen
);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A    = 3'd1,
        ST_B    = 3'd2,
        ST_C    = 3'd3,
        ST_D    = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [1:0]               cmd_r;
    logic                     din_r;
    logic                     first_r;
    logic                     busy_r;
    logic [SYNC_STAGES-1:0]   scl_sync_r;
    logic [SYNC_STAGES-1:0]   sda_sync_r;
    logic                     scl_s;
    logic                     sda_s;
    logic                     in_bc_s;
    logic                     stretch_s;
    logic                     advance_s;
    logic                     arb_lost_s;
    logic [1:0]               lines_s;
    logic                     ack_s;
    logic                     al_s;
    logic                     dout_s;
    logic                     latch_s;

    // {SCL, SDA} enable pair for a given command and phase (1 = released)
    function automatic logic [1:0] phase_lines(input logic [1:0] cmd,
                                               input state_t     ph,
                                               input logic       din);
        logic [1:0] lines;
        lines = 2'b11;
        case (cmd)
            CMD_START: begin
                case (ph)
                    ST_A:    lines = 2'b11;
                    ST_B:    lines = 2'b11;
                    ST_C:    lines = 2'b10;
                    ST_D:    lines = 2'b00;
                    default: lines = 2'b11;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    ST_A:    lines = 2'b00;
                    ST_B:    lines = 2'b10;
                    ST_C:    lines = 2'b11;
                    ST_D:    lines = 2'b11;
                    default: lines = 2'b11;
                endcase
            end
            CMD_WRITE: begin
                case (ph)
                    ST_A:    lines = {1'b0, din};
                    ST_B:    lines = {1'b1, din};
                    ST_C:    lines = {1'b1, din};
                    ST_D:    lines = {1'b0, din};
                    default: lines = 2'b11;
                endcase
            end
            CMD_READ: begin
                case (ph)
                    ST_A:    lines = 2'b01;
                    ST_B:    lines = 2'b11;
                    ST_C:    lines = 2'b11;
                    ST_D:    lines = 2'b01;
                    default: lines = 2'b11;
                endcase
            end
            default: lines = 2'b11;
        endcase
        return lines;
    endfunction

    assign scl_s   = scl_sync_r[SYNC_STAGES-1];
    assign sda_s   = sda_sync_r[SYNC_STAGES-1];
    assign in_bc_s = (state_r == ST_B) || (state_r == ST_C);

    // A released SCL still read low means a slave is stretching the clock
    assign stretch_s  = Scl_oen & ~scl_s & in_bc_s;
    // The Tick seen on the first A cycle is the timer's leftover reload pulse
    assign advance_s  = Tick & ~stretch_s & ~first_r;
    assign arb_lost_s = (cmd_r == CMD_WRITE) & din_r & ~sda_s & in_bc_s;

    assign Timer_start = (state_r == ST_IDLE) & ~Rst;
    assign Timer_stop  = stretch_s;
    assign Busy        = busy_r;

    // Next-state, next line enables and completion pulses
    always_comb begin
        state_s = state_r;
        lines_s = {Scl_oen, Sda_oen};
        ack_s   = 1'b0;
        al_s    = 1'b0;
        dout_s  = Dout;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Cmd_valid) begin
                    state_s = ST_A;
                    latch_s = 1'b1;
                    lines_s = phase_lines(Cmd, ST_A, Din);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_A: begin
                if (advance_s) begin
                    state_s = ST_B;
                    lines_s = phase_lines(cmd_r, ST_B, din_r);
                end else begin
                    state_s = ST_A;
                end
            end
            ST_B: begin
                if (arb_lost_s) begin
                    state_s = ST_IDLE;
                    lines_s = 2'b11;
                    al_s    = 1'b1;
                end else if (advance_s) begin
                    state_s = ST_C;
                    lines_s = phase_lines(cmd_r, ST_C, din_r);
                    if (cmd_r == CMD_READ) begin
                        dout_s = sda_s;
                    end else begin
                        dout_s = Dout;
                    end
                end else begin
                    state_s = ST_B;
                end
            end
            ST_C: begin
                if (arb_lost_s) begin
                    state_s = ST_IDLE;
                    lines_s = 2'b11;
                    al_s    = 1'b1;
                end else if (advance_s) begin
                    state_s = ST_D;
                    lines_s = phase_lines(cmd_r, ST_D, din_r);
                end else begin
                    state_s = ST_C;
                end
            end
            ST_D: begin
                if (advance_s) begin
                    state_s = ST_IDLE;
                    ack_s   = 1'b1;
                end else begin
                    state_s = ST_D;
                end
            end
            default: begin
                state_s = ST_IDLE;
                lines_s = 2'b11;
            end
        endcase
    end

    // State, registered outputs, command latch and pad synchronizers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            Scl_oen    <= 1'b1;
            Sda_oen    <= 1'b1;
            Cmd_ack    <= 1'b0;
            Al         <= 1'b0;
            Dout       <= 1'b0;
            first_r    <= 1'b0;
            cmd_r      <= CMD_START;
            din_r      <= 1'b0;
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != ST_IDLE);
            Scl_oen    <= lines_s[1];
            Sda_oen    <= lines_s[0];
            Cmd_ack    <= ack_s;
            Al         <= al_s;
            Dout       <= dout_s;
            first_r    <= latch_s;
            if (latch_s) begin
                cmd_r <= Cmd;
                din_r <= Din;
            end
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], Scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], Sda_i};
        end
    end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: a 3-tick timer model, pads that mirror the
// enables (with slave overrides), a command table checked through a scoreboard queue.
module tb_i2c_bit_ctrl;

    localparam int S     = 2;
    localparam int TICKS = 3;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tick;
    logic       Timer_start;
    logic       Timer_stop;
    logic [1:0] Cmd;
    logic       Cmd_valid;
    logic       Din;
    logic       Cmd_ack;
    logic       Dout;
    logic       Busy;
    logic       Al;
    logic       Scl_i;
    logic       Sda_i;
    logic       Scl_oen;
    logic       Sda_oen;
    logic       scl_slave = 1'b1;
    logic       sda_slave = 1'b1;
    logic [1:0] tmr_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] cmd;
        logic       din;
        logic       sda_lvl;
        int         hold;
        bit         poke;
        int         lat;
        logic [3:0] scl_pat;
        logic [3:0] sda_pat;
        logic       dout;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    i2c_bit_ctrl #(.SYNC_STAGES(S)) dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick),
        .Timer_start(Timer_start), .Timer_stop(Timer_stop),
        .Cmd(Cmd), .Cmd_valid(Cmd_valid), .Din(Din),
        .Cmd_ack(Cmd_ack), .Dout(Dout), .Busy(Busy), .Al(Al),
        .Scl_i(Scl_i), .Sda_i(Sda_i), .Scl_oen(Scl_oen), .Sda_oen(Sda_oen)
    );

    always #5 Clk = ~Clk;

    assign Scl_i = Scl_oen & scl_slave;
    assign Sda_i = Sda_oen & sda_slave;

    // Timer: Out high while held at reload, then one pulse every TICKS+1 cycles
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tmr_cnt <= 2'd0;
            Tick    <= 1'b0;
        end else if (Timer_start) begin
            tmr_cnt <= 2'(TICKS);
            Tick    <= 1'b1;
        end else if (!Timer_stop) begin
            tmr_cnt <= (tmr_cnt == 2'd0) ? 2'(TICKS) : tmr_cnt - 2'd1;
            Tick    <= (tmr_cnt == 2'd1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one table command and compare against the scoreboard entry on completion
    task automatic run_vec(input vec_t v);
        vec_t       e;
        int         n;
        int         ext;
        bit         done;
        bit         stop_ok;
        logic [1:0] tr[0:127];
        logic [3:0] scl_obs;
        logic [3:0] sda_obs;
        sb.push_back(v);
        sda_slave = v.sda_lvl;
        Cmd       = v.cmd;
        Din       = v.din;
        Cmd_valid = 1'b1;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        tr[0]   = {Scl_oen, Sda_oen};
        n       = 0;
        done    = 1'b0;
        stop_ok = 1'b1;
        while (!done && n < 100) begin
            @(posedge Clk); #1;
            n++;
            tr[n] = {Scl_oen, Sda_oen};
            if (n == 1) check("busy_during_cmd", int'(Busy), 1);
            if (v.poke && n == 6) begin
                Cmd       = 2'b00;
                Cmd_valid = 1'b1;
            end
            if (v.poke && n == 7) Cmd_valid = 1'b0;
            if (v.hold > 0) begin
                if (n == 4) scl_slave = 1'b0;
                if (n == 4 + v.hold) scl_slave = 1'b1;
                if (n >= 4 && n < 4 + v.hold + S && !Timer_stop) stop_ok = 1'b0;
                if (n == 4 + v.hold + S) begin
                    check("timer_stop_held", int'(stop_ok), 1);
                    check("timer_stop_release", int'(Timer_stop), 0);
                end
            end
            if (Cmd_ack || Al) done = 1'b1;
        end
        e = sb.pop_front();
        check("cmd_ack", int'(Cmd_ack), 1);
        check("no_al", int'(Al), 0);
        check("ack_latency", n, e.lat);
        check("dout", int'(Dout), int'(e.dout));
        check("busy_at_ack", int'(Busy), 0);
        ext = (e.lat > 16) ? e.lat - 16 : 0;
        scl_obs = {tr[0][1], tr[4][1], tr[8 + ext][1], tr[12 + ext][1]};
        sda_obs = {tr[0][0], tr[4][0], tr[8 + ext][0], tr[12 + ext][0]};
        check("scl_phases", int'(scl_obs), int'(e.scl_pat));
        check("sda_phases", int'(sda_obs), int'(e.sda_pat));
        if (v.poke) begin
            repeat (3) @(posedge Clk);
            #1;
            check("busy_cmd_not_queued", int'(Busy), 0);
        end
        sda_slave = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        // SCL released from low is seen only after the synchronizer, so B of such
        // bits runs S cycles longer; START begins with SCL already high.
        vecs[0] = '{2'b00, 1'b0, 1'b1, 0,  1'b0, 16,      4'b1110, 4'b1100, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 1'b1, 0,  1'b0, 16 + S,  4'b0110, 4'b0000, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 0,  1'b0, 16 + S,  4'b0110, 4'b1111, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 1'b0, 0,  1'b0, 16 + S,  4'b0110, 4'b1111, 1'b0};
        vecs[4] = '{2'b11, 1'b0, 1'b1, 0,  1'b0, 16 + S,  4'b0110, 4'b1111, 1'b1};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 0,  1'b1, 16 + S,  4'b0110, 4'b1111, 1'b1};
        vecs[6] = '{2'b10, 1'b0, 1'b1, 20, 1'b0, 36 + S,  4'b0110, 4'b0000, 1'b1};
        vecs[7] = '{2'b01, 1'b0, 1'b1, 0,  1'b0, 16 + S,  4'b0111, 4'b0011, 1'b1};
        vecs[8] = '{2'b00, 1'b0, 1'b1, 0,  1'b0, 16,      4'b1110, 4'b1100, 1'b1};
        vecs[9] = '{2'b10, 1'b1, 1'b1, 0,  1'b0, 16 + S,  4'b0110, 4'b1111, 1'b1};

        Rst       = 1'b1;
        Cmd       = 2'b00;
        Cmd_valid = 1'b0;
        Din       = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_scl_oen", int'(Scl_oen), 1);
        check("rst_sda_oen", int'(Sda_oen), 1);
        check("rst_cmd_ack", int'(Cmd_ack), 0);
        check("rst_al", int'(Al), 0);
        check("rst_dout", int'(Dout), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_timer_start", int'(Timer_start), 0);
        Rst = 1'b0;
        #1;
        check("idle_timer_start", int'(Timer_start), 1);
        repeat (2) @(posedge Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Arbitration: slave pulls SDA low while a 1 is being written in phase B
        Cmd = 2'b10; Din = 1'b1; Cmd_valid = 1'b1;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        n = 0;
        while (!(Al || Cmd_ack) && n < 100) begin
            @(posedge Clk); #1;
            n++;
            if (n == 4) sda_slave = 1'b0;
        end
        check("arb_al", int'(Al), 1);
        check("arb_no_ack", int'(Cmd_ack), 0);
        check("arb_latency", n, 4 + S + 1);
        check("arb_scl_oen", int'(Scl_oen), 1);
        check("arb_sda_oen", int'(Sda_oen), 1);
        check("arb_busy", int'(Busy), 0);
        @(posedge Clk); #1;
        check("arb_al_pulse", int'(Al), 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Cmd_ack) seen = 1'b1;
        end
        check("arb_never_acks", int'(seen), 0);
        sda_slave = 1'b1;
        repeat (3) @(posedge Clk);
        #1;

        // Reset during STOP phase B aborts without acknowledge
        Cmd = 2'b01; Din = 1'b0; Cmd_valid = 1'b1;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("midrst_busy", int'(Busy), 0);
        check("midrst_scl_oen", int'(Scl_oen), 1);
        check("midrst_sda_oen", int'(Sda_oen), 1);
        check("midrst_no_ack", int'(Cmd_ack), 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Cmd_ack) seen = 1'b1;
        end
        check("midrst_never_acks", int'(seen), 0);
        run_vec('{2'b00, 1'b0, 1'b1, 0, 1'b0, 16, 4'b1110, 4'b1100, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
